// File: rtl/bit_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// bit_serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//   - state encodings for the sequencing FSM (3 is illegal, recovers to idle)
//   - cnt_width(): width of the bit counter, max(1, clog2(width))
// -----------------------------------------------------------------------------
package bit_serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DONE    = 2'd2,
      ST_ILLEGAL = 2'd3
   } state_t;

   // A 1-bit operand still needs a 1-bit counter, so clamp at 1.
   function automatic int cnt_width(input int width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// half_adder / full_adder
//   The single-bit adder cell used by the bit-serial adder. The full adder is
//   two half adders with their carries OR-ed together.
//   half_adder ports: a, b -> s, co
//   full_adder ports: a, b, ci -> s, co
// -----------------------------------------------------------------------------
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic co
);

   assign s  = a ^ b;
   assign co = a & b;

endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic s_ab;
   logic c_ab;
   logic c_abc;

   half_adder u_ha_ab (
      .a  (a),
      .b  (b),
      .s  (s_ab),
      .co (c_ab)
   );

   half_adder u_ha_abc (
      .a  (s_ab),
      .b  (ci),
      .s  (s),
      .co (c_abc)
   );

   // Both half-adder carries can never be high together, so OR is exact.
   assign co = c_ab | c_abc;

endmodule

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//   Multi-cycle WIDTH-bit adder. Operands are shifted through one full_adder
//   LSB-first, one bit per clock; a carry flop links successive bits.
//   Valid/ready handshake on both sides, no overlap of operations.
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   operand pair offered
//     in_ready   out  operands can be accepted (idle)
//     a, b       in   WIDTH-bit operands
//     cin        in   carry-in
//     out_valid  out  result available
//     out_ready  in   downstream accepts result
//     sum        out  (a+b+cin) mod 2^WIDTH, held until the next result
//     cout       out  carry out of bit WIDTH-1
//     busy       out  operation in progress or result pending
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for operands, in_ready high
//   RUN     | adding one bit per clock, exactly WIDTH cycles
//   DONE    | result presented on sum/cout with out_valid high
//   ILLEGAL | unreachable encoding, recovers to IDLE
// -----------------------------------------------------------------------------
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_sh_nxt;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_co;

   full_adder u_full_adder (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the
   // result has reached bit 0. Written this way so WIDTH=1 needs no slice.
   always_comb begin
      sum_sh_nxt            = sum_sh >> 1;
      sum_sh_nxt[WIDTH-1]   = fa_s;
   end

   assign in_ready = (state == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         sum_sh    <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  sum_sh <= '0;
                  carry  <= cin;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_RUN;
               end
            end

            ST_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= sum_sh_nxt;
               carry  <= fa_co;
               if (cnt == CNT_LAST) begin
                  sum       <= sum_sh_nxt;
                  cout      <= fa_co;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
//   Directed bench for bit_serial_adder (WIDTH=8 and WIDTH=1 instances).
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;

   logic       clk;
   logic       rst_n;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;
   logic       busy;

   logic       in_valid_w1;
   logic       in_ready_w1;
   logic [0:0] a_w1;
   logic [0:0] b_w1;
   logic       cin_w1;
   logic       out_valid_w1;
   logic       out_ready_w1;
   logic [0:0] sum_w1;
   logic       cout_w1;
   logic       busy_w1;

   int n_assert;
   int n_fail;
   int cyc;

   bit_serial_adder #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   bit_serial_adder #(.WIDTH(1)) dut_w1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_w1),
      .in_ready  (in_ready_w1),
      .a         (a_w1),
      .b         (b_w1),
      .cin       (cin_w1),
      .out_valid (out_valid_w1),
      .out_ready (out_ready_w1),
      .sum       (sum_w1),
      .cout      (cout_w1),
      .busy      (busy_w1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand pair with out_ready low, scramble the inputs right
   // after acceptance, and return the number of edges after acceptance
   // until out_valid is seen.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        output int lat);
      int guard;
      a        = ta;
      b        = tb;
      cin      = tc;
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 50) begin
         step();
         guard++;
      end
      step();
      in_valid = 1'b0;
      a        = ~ta;
      b        = ~tb;
      cin      = ~tc;
      lat      = 0;
      while (!out_valid && lat < 50) begin
         step();
         lat++;
      end
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_ov_clr"}, out_valid, 1'b0);
      chk({tag, "_in_rdy"}, in_ready, 1'b1);
      chk({tag, "_busy_clr"}, busy, 1'b0);
   endtask

   initial begin
      int         lat;
      int         seen;
      int         prev_t;
      int         guard;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic [8:0] exp9;

      n_assert     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      a            = '0;
      b            = '0;
      cin          = 1'b0;
      out_ready    = 1'b0;
      in_valid_w1  = 1'b0;
      a_w1         = '0;
      b_w1         = '0;
      cin_w1       = 1'b0;
      out_ready_w1 = 1'b0;

      // reset state
      step();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_sum", sum, 8'h00);
      chk("rst_cout", cout, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      step();

      // 1: 0F + 01
      do_op(8'h0F, 8'h01, 1'b0, lat);
      chk("t1_latency", lat, 8);
      chk("t1_sum", sum, 8'h10);
      chk("t1_cout", cout, 1'b0);
      chk("t1_in_ready_done", in_ready, 1'b0);
      chk("t1_busy_done", busy, 1'b1);
      drain("t1");

      // 2: carry ripple through all bits
      do_op(8'hFF, 8'h01, 1'b0, lat);
      chk("t2a_latency", lat, 8);
      chk("t2a_sum", sum, 8'h00);
      chk("t2a_cout", cout, 1'b1);
      drain("t2a");
      do_op(8'hFF, 8'hFF, 1'b1, lat);
      chk("t2b_sum", sum, 8'hFF);
      chk("t2b_cout", cout, 1'b1);
      drain("t2b");

      // 3: backpressure in DONE, in_valid pulses ignored
      do_op(8'h12, 8'h34, 1'b0, lat);
      chk("t3_sum", sum, 8'h46);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         a        = 8'hC3;
         b        = 8'h3C;
         step();
         chk("t3_hold_ov", out_valid, 1'b1);
         chk("t3_hold_sum", sum, 8'h46);
         chk("t3_hold_cout", cout, 1'b0);
         chk("t3_hold_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      drain("t3");
      chk("t3_sum_kept_idle", sum, 8'h46);
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      chk("t3_oready_idle_ignored", out_valid, 1'b0);
      chk("t3_sum_still_kept", sum, 8'h46);

      // 4: reset during the 3rd RUN cycle
      a        = 8'h33;
      b        = 8'h44;
      cin      = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("t4_busy_in_run", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_ov", out_valid, 1'b0);
      chk("t4_rst_sum", sum, 8'h00);
      chk("t4_rst_cout", cout, 1'b0);
      chk("t4_rst_busy", busy, 1'b0);
      chk("t4_rst_in_ready", in_ready, 1'b1);
      step();
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen = 1;
      end
      chk("t4_no_aborted_result", seen, 0);
      do_op(8'h55, 8'hAA, 1'b1, lat);
      chk("t4_latency", lat, 8);
      chk("t4_sum", sum, 8'h00);
      chk("t4_cout", cout, 1'b1);
      drain("t4");

      // 5: back-to-back random ops
      out_ready = 1'b1;
      in_valid  = 1'b1;
      prev_t    = 0;
      for (int i = 0; i < 1000; i++) begin
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rc   = 1'($urandom);
         a    = ra;
         b    = rb;
         cin  = rc;
         exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
         guard = 0;
         while (!in_ready && guard < 50) begin
            step();
            guard++;
         end
         step();
         a   = 8'($urandom);
         b   = 8'($urandom);
         cin = 1'($urandom);
         lat = 0;
         while (!out_valid && lat < 50) begin
            step();
            lat++;
         end
         chk("t5_sum", sum, exp9[7:0]);
         chk("t5_cout", cout, exp9[8]);
         if (i > 0) chk("t5_period", cyc - prev_t, 10);
         prev_t = cyc;
      end
      in_valid = 1'b0;
      step();
      step();
      out_ready = 1'b0;
      chk("t5_end_idle", in_ready, 1'b1);

      // 6: WIDTH=1 instance
      a_w1        = 1'b1;
      b_w1        = 1'b1;
      cin_w1      = 1'b1;
      in_valid_w1 = 1'b1;
      step();
      in_valid_w1 = 1'b0;
      a_w1        = 1'b0;
      b_w1        = 1'b0;
      cin_w1      = 1'b0;
      chk("t6_not_yet_valid", out_valid_w1, 1'b0);
      step();
      chk("t6_valid_after_1", out_valid_w1, 1'b1);
      chk("t6_sum", sum_w1, 1'b1);
      chk("t6_cout", cout_w1, 1'b1);
      out_ready_w1 = 1'b1;
      step();
      out_ready_w1 = 1'b0;
      chk("t6_ov_clr", out_valid_w1, 1'b0);
      a_w1        = 1'b1;
      b_w1        = 1'b0;
      cin_w1      = 1'b0;
      in_valid_w1 = 1'b1;
      step();
      in_valid_w1 = 1'b0;
      step();
      chk("t6b_valid", out_valid_w1, 1'b1);
      chk("t6b_sum", sum_w1, 1'b1);
      chk("t6b_cout", cout_w1, 1'b0);
      out_ready_w1 = 1'b1;
      step();
      out_ready_w1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
